n_input_or_monitor: RTL and testbench

N_INPUT_OR_MONITOR -- requirements
Module: n_input_or_monitor

---
 rtl/n_input_or_monitor.sv | 101 ++++++++++
 tb/tb_n_input_or_monitor.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/n_input_or_monitor.sv
// N-input OR monitor: registered OR/NOR, sticky flag, saturating rise counter
// and a pulse stretcher that holds the output for HOLD enabled cycles.
module n_input_or_monitor #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    input  logic             clr,
    output logic             y,
    output logic             yn,
    output logic             sticky,
    output logic             stretch,
    output logic [CNT_W-1:0] rise_cnt,
    output logic             cnt_sat
);

    localparam int HW = (HOLD < 1) ? 1 : $clog2(HOLD + 1);
    localparam logic [HW-1:0]    HOLD_V  = HW'(HOLD);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             or_now;
    logic             rise;
    logic             y_q, y_d;
    logic             yn_q, yn_d;
    logic             sticky_q, sticky_d;
    logic             stretch_q, stretch_d;
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
    logic             cnt_sat_q, cnt_sat_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;

    assign or_now = |in;
    assign rise   = en && or_now && !y_q;

    always_comb begin
        y_d        = y_q;
        yn_d       = yn_q;
        sticky_d   = sticky_q;
        stretch_d  = stretch_q;
        rise_cnt_d = rise_cnt_q;
        hcnt_d     = hcnt_q;

        if (en) begin
            y_d  = or_now;
            yn_d = ~or_now;
            if (or_now) begin
                hcnt_d    = HOLD_V;
                stretch_d = 1'b1;
            end else if (hcnt_q != '0) begin
                hcnt_d    = hcnt_q - HW'(1);
                stretch_d = 1'b1;
            end else begin
                stretch_d = 1'b0;
            end
        end

        // clr overrides any same-edge rise or sticky set; y keeps updating.
        if (clr) begin
            sticky_d   = 1'b0;
            rise_cnt_d = '0;
        end else begin
            if (en && or_now)
                sticky_d = 1'b1;
            if (rise && rise_cnt_q != CNT_MAX)
                rise_cnt_d = rise_cnt_q + CNT_W'(1);
        end

        cnt_sat_d = (rise_cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q        <= 1'b0;
            yn_q       <= 1'b1;
            sticky_q   <= 1'b0;
            stretch_q  <= 1'b0;
            rise_cnt_q <= '0;
            cnt_sat_q  <= 1'b0;
            hcnt_q     <= '0;
        end else begin
            y_q        <= y_d;
            yn_q       <= yn_d;
            sticky_q   <= sticky_d;
            stretch_q  <= stretch_d;
            rise_cnt_q <= rise_cnt_d;
            cnt_sat_q  <= cnt_sat_d;
            hcnt_q     <= hcnt_d;
        end
    end

    assign y        = y_q;
    assign yn       = yn_q;
    assign sticky   = sticky_q;
    assign stretch  = stretch_q;
    assign rise_cnt = rise_cnt_q;
    assign cnt_sat  = cnt_sat_q;

endmodule

// File: tb/tb_n_input_or_monitor.sv
// Bench for n_input_or_monitor: two instances (HOLD=0/CNT_W=8 and HOLD=4/CNT_W=2)
// on shared stimulus, checked each cycle against a behavioural model plus literals.
module tb_n_input_or_monitor;

    logic       clk = 0;
    logic       rst, en, clr;
    logic [2:0] in;

    logic       a_y, a_yn, a_sticky, a_stretch, a_cnt_sat;
    logic [7:0] a_cnt;
    logic       b_y, b_yn, b_sticky, b_stretch, b_cnt_sat;
    logic [1:0] b_cnt;

    int checks = 0;
    int failures = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    n_input_or_monitor #(.WIDTH(3), .CNT_W(8), .HOLD(0)) dut_a (
        .clk(clk), .rst(rst), .in(in), .en(en), .clr(clr),
        .y(a_y), .yn(a_yn), .sticky(a_sticky), .stretch(a_stretch),
        .rise_cnt(a_cnt), .cnt_sat(a_cnt_sat)
    );

    n_input_or_monitor #(.WIDTH(3), .CNT_W(2), .HOLD(4)) dut_b (
        .clk(clk), .rst(rst), .in(in), .en(en), .clr(clr),
        .y(b_y), .yn(b_yn), .sticky(b_sticky), .stretch(b_stretch),
        .rise_cnt(b_cnt), .cnt_sat(b_cnt_sat)
    );

    // Model: stretch is high while the number of enabled samples since the last
    // OR=1 sample is at most HOLD; rises are 0->1 steps of the sampled OR.
    localparam int BIG = 1000;
    int m_y = 0, m_sticky = 0, m_cnt_a = 0, m_cnt_b = 0, m_since = BIG;

    always @(posedge clk) begin
        if (rst) begin
            m_y <= 0; m_sticky <= 0; m_cnt_a <= 0; m_cnt_b <= 0; m_since <= BIG;
        end else begin
            if (en) begin
                m_y <= (in != 0);
                if (in != 0) m_since <= 0;
                else if (m_since < BIG) m_since <= m_since + 1;
            end
            if (clr) begin
                m_sticky <= 0; m_cnt_a <= 0; m_cnt_b <= 0;
            end else if (en && in != 0) begin
                m_sticky <= 1;
                if (m_y == 0) begin
                    m_cnt_a <= (m_cnt_a < 255) ? m_cnt_a + 1 : 255;
                    m_cnt_b <= (m_cnt_b < 3) ? m_cnt_b + 1 : 3;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_y", a_y, m_y);
            chk("a_yn", a_yn, 1 - m_y);
            chk("a_sticky", a_sticky, m_sticky);
            chk("a_stretch", a_stretch, (m_since <= 0) ? 1 : 0);
            chk("a_cnt", a_cnt, m_cnt_a);
            chk("a_cnt_sat", a_cnt_sat, (m_cnt_a == 255) ? 1 : 0);
            chk("b_y", b_y, m_y);
            chk("b_yn", b_yn, 1 - m_y);
            chk("b_sticky", b_sticky, m_sticky);
            chk("b_stretch", b_stretch, (m_since <= 4) ? 1 : 0);
            chk("b_cnt", b_cnt, m_cnt_b);
            chk("b_cnt_sat", b_cnt_sat, (m_cnt_b == 3) ? 1 : 0);
        end
    end

    task automatic cyc(input logic [2:0] v, input logic e, input logic c);
        in = v; en = e; clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; in = 0; en = 0; clr = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_on = 1;
        chk("rst_y", a_y, 0);
        chk("rst_yn", a_yn, 1);
        chk("rst_stretch", b_stretch, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_sat", b_cnt_sat, 0);
        rst = 0;

        // Exhaustive sweep (dut_a, HOLD=0): stretch must track y exactly.
        for (int v = 0; v < 8; v++) begin
            cyc(3'(v), 1, 0);
            chk("sweep_y", a_y, (v != 0) ? 1 : 0);
            chk("sweep_yn", a_yn, (v != 0) ? 0 : 1);
            chk("sweep_stretch_eq_y", a_stretch, a_y);
        end
        chk("sweep_rises", a_cnt, 1);
        chk("sweep_sticky", a_sticky, 1);

        // Basic stretch on dut_b: 1 high sample -> 5 cycles of stretch.
        for (int i = 0; i < 6; i++) cyc(3'b000, 1, 0);
        begin
            logic [2:0] sv [7];
            int exp_st [7];
            sv = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
            exp_st = '{1, 1, 1, 1, 1, 0, 0};
            for (int i = 0; i < 7; i++) begin
                cyc(sv[i], 1, 0);
                chk("stretch_basic", b_stretch, exp_st[i]);
                chk("stretch_y", b_y, (i == 0) ? 1 : 0);
            end
        end
        // Retrigger with 100 on the 3rd low cycle.
        begin
            logic [2:0] sv [10];
            int exp_st [10];
            sv = '{3'b001, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
            exp_st = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
            for (int i = 0; i < 10; i++) begin
                cyc(sv[i], 1, 0);
                chk("stretch_retrig", b_stretch, exp_st[i]);
            end
        end

        // Saturation on dut_b (CNT_W=2).
        cyc(3'b000, 1, 1);
        chk("clr_cnt", b_cnt, 0);
        begin
            int exp_c [5];
            exp_c = '{1, 2, 3, 3, 3};
            for (int i = 0; i < 5; i++) begin
                cyc(3'b010, 1, 0);
                chk("sat_cnt", b_cnt, exp_c[i]);
                chk("sat_flag", b_cnt_sat, (exp_c[i] == 3) ? 1 : 0);
                cyc(3'b000, 1, 0);
            end
        end

        // Clear colliding with a rise.
        cyc(3'b000, 1, 1);
        cyc(3'b001, 1, 0); cyc(3'b000, 1, 0);
        cyc(3'b001, 1, 0); cyc(3'b000, 1, 0);
        chk("pre_clr_cnt", a_cnt, 2);
        chk("pre_clr_sticky", a_sticky, 1);
        cyc(3'b001, 1, 1);
        chk("coll_cnt", a_cnt, 0);
        chk("coll_sticky", a_sticky, 0);
        chk("coll_sat", a_cnt_sat, 0);
        chk("coll_y", a_y, 1);

        // Enable freeze mid-stretch (hcnt=2).
        for (int i = 0; i < 6; i++) cyc(3'b000, 1, 0);
        cyc(3'b001, 1, 0);
        cyc(3'b000, 1, 0);
        cyc(3'b000, 1, 0);
        cyc(3'b111, 0, 0);
        cyc(3'b010, 0, 0);
        cyc(3'b000, 0, 0);
        chk("frz_y", b_y, 0);
        chk("frz_stretch", b_stretch, 1);
        chk("frz_cnt", b_cnt, 1);
        cyc(3'b000, 1, 0); chk("frz_rem1", b_stretch, 1);
        cyc(3'b000, 1, 0); chk("frz_rem2", b_stretch, 1);
        cyc(3'b000, 1, 0); chk("frz_done", b_stretch, 0);

        // Reset mid-stretch / mid-count.
        cyc(3'b000, 1, 1);
        cyc(3'b001, 1, 0); cyc(3'b000, 1, 0);
        cyc(3'b001, 1, 0); cyc(3'b000, 1, 0);
        cyc(3'b001, 1, 0);
        chk("pre_rst_cnt", a_cnt, 3);
        chk("pre_rst_stretch", b_stretch, 1);
        rst = 1;
        cyc(3'b000, 1, 0);
        rst = 0;
        chk("mrst_y", b_y, 0);
        chk("mrst_yn", b_yn, 1);
        chk("mrst_stretch", b_stretch, 0);
        chk("mrst_cnt", a_cnt, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(3'b000, 1, 0);
            chk("no_residual", b_stretch, 0);
        end
        cyc(3'b001, 1, 0);
        chk("post_rst_rise", a_cnt, 1);
        cyc(3'b000, 1, 0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
